// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite SRAM slave.
//   RESP_*  : AXI response encodings
//   gnt_e   : which requester owns the single SRAM port this cycle
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } gnt_e;

endpackage

// File: rtl/sram_be_sp.sv
// Single-port SRAM with synchronous read and per-byte write enables.
//   clk   : clock
//   en    : access enable
//   we    : per-byte write enable (all zero = read)
//   addr  : word index
//   wdata : write data
//   rdata : read data, registered
module sram_be_sp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic [DATA_W/8-1:0]        we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // The read register only loads on a pure read, so a write issued while
    // a read response is still waiting for RREADY leaves that data intact.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we == '0) begin
                r_rdata <= r_mem[addr];
            end
            for (int b = 0; b < STRB_W; b++) begin
                if (we[b]) begin
                    r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave in front of a single-port byte-enabled SRAM.
//   clk, rst_n            : clock, async active-low reset
//   s_aw* / s_w* / s_b*   : write address, write data, write response channels
//   s_ar* / s_r*          : read address, read data channels
// AW and W are buffered independently; a write commits once both are held
// and no B is pending. One read is outstanding at a time. Reads and writes
// share the SRAM port through a round-robin arbiter.
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [2:0]          s_awprot,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [2:0]          s_arprot,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LAST   = RD_LAT - 1;
    localparam logic [ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] SPAN_EXT = (ADDR_W+1)'(DEPTH * STRB_W);

    logic                r_rdy_en;
    logic                r_aw_full, r_w_full, r_ar_pend, r_rd_busy;
    logic [ADDR_W-1:0]   r_aw_addr, r_ar_addr;
    logic [DATA_W-1:0]   r_w_data;
    logic [STRB_W-1:0]   r_w_strb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rr;
    logic [RD_LAT-1:0]   r_pv, r_pe;

    logic [RD_LAT-1:0]   w_pv_nxt, w_pe_nxt;
    logic [ADDR_W:0]     w_wr_diff, w_rd_diff;
    logic                w_wr_in, w_rd_in;
    logic [IDX_W-1:0]    w_wr_idx, w_rd_idx;
    logic                w_wr_req, w_rd_req;
    logic                w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    gnt_e                w_gnt;
    logic                w_sram_en;
    logic [STRB_W-1:0]   w_sram_we;
    logic [IDX_W-1:0]    w_sram_addr;
    logic [DATA_W-1:0]   w_sram_rdata;
    logic                w_unused;

    // Subtract with one extra bit: an address below BASE borrows into the
    // top bit and so compares larger than the span, failing the range check.
    assign w_wr_diff = {1'b0, r_aw_addr} - BASE_EXT;
    assign w_rd_diff = {1'b0, r_ar_addr} - BASE_EXT;
    assign w_wr_in   = w_wr_diff < SPAN_EXT;
    assign w_rd_in   = w_rd_diff < SPAN_EXT;
    assign w_wr_idx  = w_wr_diff[OFF_W +: IDX_W];
    assign w_rd_idx  = w_rd_diff[OFF_W +: IDX_W];

    assign s_awready = r_rdy_en & ~r_aw_full;
    assign s_wready  = r_rdy_en & ~r_w_full;
    assign s_arready = r_rdy_en & ~r_rd_busy;
    assign w_aw_hs   = s_awvalid & s_awready;
    assign w_w_hs    = s_wvalid & s_wready;
    assign w_ar_hs   = s_arvalid & s_arready;
    assign w_r_hs    = s_rvalid & s_rready;

    assign w_wr_req  = r_aw_full & r_w_full & ~r_bvalid;
    assign w_rd_req  = r_ar_pend;

    // r_rr = 0 favours the read on a contested cycle, 1 favours the write.
    always_comb begin
        w_gnt = GNT_NONE;
        if (w_rd_req && w_wr_req) begin
            w_gnt = r_rr ? GNT_WR : GNT_RD;
        end else if (w_rd_req) begin
            w_gnt = GNT_RD;
        end else if (w_wr_req) begin
            w_gnt = GNT_WR;
        end
    end

    // A zero-strobe or out-of-range write never touches the array.
    always_comb begin
        w_sram_en   = 1'b0;
        w_sram_we   = '0;
        w_sram_addr = w_rd_idx;
        if (w_gnt == GNT_RD) begin
            w_sram_en = w_rd_in;
        end else if (w_gnt == GNT_WR) begin
            w_sram_addr = w_wr_idx;
            w_sram_en   = w_wr_in & (|r_w_strb);
            w_sram_we   = w_wr_in ? r_w_strb : '0;
        end
    end

    // Read pipeline: valid/error travel RD_LAT stages; the final stage holds
    // until RREADY. Data stays in the SRAM read register, which cannot be
    // reloaded while this read is outstanding.
    always_comb begin
        w_pv_nxt    = '0;
        w_pe_nxt    = '0;
        w_pv_nxt[0] = (w_gnt == GNT_RD);
        w_pe_nxt[0] = (w_gnt == GNT_RD) & ~w_rd_in;
        for (int i = 1; i < RD_LAT; i++) begin
            w_pv_nxt[i] = r_pv[i-1];
            w_pe_nxt[i] = r_pe[i-1];
        end
        if (r_pv[LAST] && !s_rready) begin
            w_pv_nxt[LAST] = 1'b1;
            w_pe_nxt[LAST] = r_pe[LAST];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en  <= 1'b0;
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_ar_pend <= 1'b0;
            r_rd_busy <= 1'b0;
            r_ar_addr <= '0;
            r_rr      <= 1'b0;
            r_pv      <= '0;
            r_pe      <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= s_awaddr;
            end else if (w_gnt == GNT_WR) begin
                r_aw_full <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= s_wdata;
                r_w_strb <= s_wstrb;
            end else if (w_gnt == GNT_WR) begin
                r_w_full <= 1'b0;
            end
            if (w_gnt == GNT_WR) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
            end else if (s_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_ar_pend <= 1'b1;
                r_rd_busy <= 1'b1;
                r_ar_addr <= s_araddr;
            end else begin
                if (w_gnt == GNT_RD) r_ar_pend <= 1'b0;
                if (w_r_hs)          r_rd_busy <= 1'b0;
            end
            if (w_rd_req && w_wr_req) r_rr <= ~r_rr;
            r_pv <= w_pv_nxt;
            r_pe <= w_pe_nxt;
        end
    end

    sram_be_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    (w_sram_en),
        .we    (w_sram_we),
        .addr  (w_sram_addr),
        .wdata (r_w_data),
        .rdata (w_sram_rdata)
    );

    assign s_bvalid = r_bvalid;
    assign s_bresp  = r_bresp;
    assign s_rvalid = r_pv[LAST];
    assign s_rresp  = (r_pv[LAST] & r_pe[LAST]) ? RESP_SLVERR : RESP_OKAY;
    assign s_rdata  = (r_pv[LAST] & ~r_pe[LAST]) ? w_sram_rdata : '0;

    assign w_unused = ^{s_awprot, s_arprot, w_wr_diff, w_rd_diff};

endmodule
